// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer for the shared RV32I ALU: grant, issue, capture, respond.
// Define ALU_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.
module alu_share_arb #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [4:0]        req0_opcode,
    input  logic [4:0]        req1_opcode,
    input  logic [2:0]        req0_func3,
    input  logic [2:0]        req1_func3,
    input  logic [6:0]        req0_func7,
    input  logic [6:0]        req1_func7,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    output logic              resp0_valid,
    output logic              resp1_valid,
    input  logic              resp0_ready,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [4:0]        alu_opcode,
    output logic [2:0]        alu_func3,
    output logic [6:0]        alu_func7,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic              owner_r;
    logic              grant_s;
    logic              handshake_s;
    logic              resp_ack_s;
    logic [4:0]        sel_opcode_s;
    logic [2:0]        sel_func3_s;
    logic [6:0]        sel_func7_s;
    logic [DATA_W-1:0] sel_op1_s;
    logic [DATA_W-1:0] sel_op2_s;

`ifdef ALU_ARB_RR_EN
    logic last_grant_r;

    // Round-robin grant: contention goes to whoever was not served last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Remember the last winner; reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (handshake_s) begin
            last_grant_r <= grant_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed-priority grant: requester 1 only wins when requester 0 is idle.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid) begin
            grant_s = 1'b0;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end
`endif

    // Request ready: only in IDLE, and only for the granted requester.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_r == IDLE) begin
            req0_ready = req0_valid && !grant_s;
            req1_ready = req1_valid && grant_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    assign handshake_s = req0_ready | req1_ready;
    assign busy        = (state_r != IDLE);

    // Operation field mux from the granted requester.
    always_comb begin
        sel_opcode_s = req0_opcode;
        sel_func3_s  = req0_func3;
        sel_func7_s  = req0_func7;
        sel_op1_s    = req0_op1;
        sel_op2_s    = req0_op2;
        if (grant_s) begin
            sel_opcode_s = req1_opcode;
            sel_func3_s  = req1_func3;
            sel_func7_s  = req1_func7;
            sel_op1_s    = req1_op1;
            sel_op2_s    = req1_op2;
        end else begin
            sel_opcode_s = req0_opcode;
            sel_func3_s  = req0_func3;
            sel_func7_s  = req0_func7;
            sel_op1_s    = req0_op1;
            sel_op2_s    = req0_op2;
        end
    end

    // Only the owner's ready can retire the response.
    always_comb begin
        resp_ack_s = 1'b0;
        if (owner_r) begin
            resp_ack_s = resp1_ready;
        end else begin
            resp_ack_s = resp0_ready;
        end
    end

    // Sequencer FSM: issue to ALU, capture result, hold response until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            alu_opcode   <= 5'd0;
            alu_func3    <= 3'd0;
            alu_func7    <= 7'd0;
            alu_operand1 <= {DATA_W{1'b0}};
            alu_operand2 <= {DATA_W{1'b0}};
            resp_data    <= {DATA_W{1'b0}};
            resp0_valid  <= 1'b0;
            resp1_valid  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        alu_opcode   <= sel_opcode_s;
                        alu_func3    <= sel_func3_s;
                        alu_func7    <= sel_func7_s;
                        alu_operand1 <= sel_op1_s;
                        alu_operand2 <= sel_op2_s;
                        owner_r      <= grant_s;
                        state_r      <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    resp_data   <= alu_out;
                    resp0_valid <= ~owner_r;
                    resp1_valid <= owner_r;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (resp_ack_s) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed scoreboard bench for alu_share_arb with a small behavioural RV32I ALU model.
// Contention section follows ALU_ARB_RR_EN the same way the design does.
module tb_alu_share_arb;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]   req0_opcode, req1_opcode;
    logic [2:0]   req0_func3, req1_func3;
    logic [6:0]   req0_func7, req1_func7;
    logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic         resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [W-1:0] resp_data;
    logic [4:0]   alu_opcode;
    logic [2:0]   alu_func3;
    logic [6:0]   alu_func7;
    logic [W-1:0] alu_operand1, alu_operand2, alu_out;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    // Reference ALU: R-type arithmetic/logic and branch compares.
    function automatic logic [W-1:0] alu_ref(input logic [4:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] r;
        r = 32'd0;
        case (op)
            5'b01100: case (f3)
                3'b000:  r = f7[5] ? a - b : a + b;
                3'b100:  r = a ^ b;
                3'b110:  r = a | b;
                3'b111:  r = a & b;
                default: r = 32'd0;
            endcase
            5'b11000: case (f3)
                3'b000:  r = {31'd0, a == b};
                3'b001:  r = {31'd0, a != b};
                3'b100:  r = {31'd0, $signed(a) < $signed(b)};
                default: r = 32'd0;
            endcase
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign alu_out = alu_ref(alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2);

    alu_share_arb #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
        .req0_func3(req0_func3), .req1_func3(req1_func3),
        .req0_func7(req0_func7), .req1_func7(req1_func7),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_data(resp_data),
        .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func7(alu_func7),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_out(alu_out), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit n, input logic [4:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [W-1:0] a, input logic [W-1:0] b);
        if (n) begin
            req1_opcode = op; req1_func3 = f3; req1_func7 = f7; req1_op1 = a; req1_op2 = b;
        end else begin
            req0_opcode = op; req0_func3 = f3; req0_func7 = f7; req0_op1 = a; req0_op2 = b;
        end
    endtask

    // Present one request, wait for its handshake, verify the ALU drive afterwards.
    task automatic issue(input bit n, input logic [4:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input bit push);
        int cyc = 0;
        bit got = 1'b0;
        set_req(n, op, f3, f7, a, b);
        if (n) req1_valid = 1'b1; else req0_valid = 1'b1;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            got = n ? req1_ready : req0_ready;
        end
        check("req_handshake", 64'(got), 64'd1);
        if (push) sb.push_back({n, exp});
        @(posedge clk);
        #1;
        if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
        check("alu_fields", {alu_opcode, alu_func3, alu_func7}, {op, f3, f7});
        check("alu_operands", {alu_operand1, alu_operand2}, {a, b});
    endtask

    // Wait for a response, compare it with the scoreboard head.
    task automatic wait_resp(output int cyc);
        bit got = 1'b0;
        logic [W:0] e;
        cyc = 0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            got = resp0_valid | resp1_valid;
        end
        check("resp_seen", 64'(got), 64'd1);
        if (got) begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("resp_owner", {resp1_valid, resp0_valid}, e[W] ? 64'd2 : 64'd1);
                check("resp_data", 64'(resp_data), 64'(e[W-1:0]));
                check("no_ready_busy", {req0_ready, req1_ready}, 64'd0);
            end
        end
    endtask

    task automatic collect();
        int cyc;
        wait_resp(cyc);
        check("latency", 64'(cyc), 64'd2);
        @(posedge clk);
        #1;
    endtask

    // Keep both requesters valid; check each grant and the returned result.
    task automatic contend(input int nops, input bit rr);
        bit exp_n;
        for (int i = 0; i < nops; i++) begin
            int cyc = 0;
            bit got = 1'b0;
            while (!got && cyc < 10) begin
                @(negedge clk);
                cyc++;
                got = req0_ready | req1_ready;
            end
            check("contend_ready", 64'(got), 64'd1);
            check("one_ready", 64'(req0_ready & req1_ready), 64'd0);
            exp_n = rr ? 1'(i % 2) : 1'b0;
            check("grant", 64'(req1_ready), 64'(exp_n));
            if (exp_n)
                sb.push_back({1'b1, alu_ref(req1_opcode, req1_func3, req1_func7, req1_op1, req1_op2)});
            else
                sb.push_back({1'b0, alu_ref(req0_opcode, req0_func3, req0_func7, req0_op1, req0_op2)});
            @(posedge clk);
            #1;
            set_req(exp_n, 5'b01100, 3'b000, exp_n ? 7'b0100000 : 7'b0000000,
                    32'(i * 17 + 40), 32'(i * 5 + 1));
            collect();
        end
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        set_req(1'b0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0);
        set_req(1'b1, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", {resp0_valid, resp1_valid}, 64'd0);
        check("rst_alu", {alu_opcode, alu_func3, alu_func7, alu_operand1, alu_operand2}, 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_ready", {req0_ready, req1_ready}, 64'd0);
        @(posedge clk);
        #1;

        // Single add on requester 0, branch compares on requester 1, a few more patterns.
        issue(1'b0, 5'b01100, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd12, 1'b1);
        collect();
        issue(1'b1, 5'b11000, 3'b000, 7'b0000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1, 1'b1);
        collect();
        issue(1'b1, 5'b11000, 3'b001, 7'b0000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 1'b1);
        collect();
        issue(1'b0, 5'b01100, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd7, 1'b1);
        collect();
        issue(1'b1, 5'b01100, 3'b100, 7'b0000000, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b1);
        collect();

        // Backpressure on requester 0 while requester 1 waits.
        resp0_ready = 1'b0;
        issue(1'b0, 5'b01100, 3'b000, 7'b0000000, 32'd100, 32'd58, 32'd158, 1'b1);
        set_req(1'b1, 5'b01100, 3'b000, 7'b0100000, 32'd50, 32'd8);
        req1_valid = 1'b1;
        wait_resp(cyc);
        check("bp_latency", 64'(cyc), 64'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {resp0_valid, resp1_valid}, 64'd2);
            check("bp_data", 64'(resp_data), 64'd158);
            check("bp_alu", {alu_operand1, alu_operand2}, {32'd100, 32'd58});
            check("bp_req1_ready", 64'(req1_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        resp0_ready = 1'b1;
        @(negedge clk);
        check("bp_still_valid", 64'(resp0_valid), 64'd1);
        sb.push_back({1'b1, 32'd42});
        @(negedge clk);
        check("bp_released", {resp0_valid, busy}, 64'd0);
        check("bp_req1_granted", 64'(req1_ready), 64'd1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        collect();

        // Reset while the op is in EXEC abandons it.
        issue(1'b0, 5'b01100, 3'b111, 7'b0000000, 32'h0000F0F0, 32'h0000FF00, 32'd0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_alu", {alu_opcode, alu_func3, alu_func7, alu_operand1}, 64'd0);
        check("mid_rst_data", 64'(resp_data), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_rst_no_resp", {resp0_valid, resp1_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Contention with both requesters valid throughout.
        set_req(1'b0, 5'b01100, 3'b000, 7'b0000000, 32'd1000, 32'd234);
        set_req(1'b1, 5'b01100, 3'b000, 7'b0100000, 32'd900, 32'd1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
`ifdef ALU_ARB_RR_EN
        contend(4, 1'b1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`else
        contend(10, 1'b0);
        req0_valid = 1'b0;
        @(negedge clk);
        check("fp_req1_after_drop", {req0_ready, req1_ready}, 64'd1);
        sb.push_back({1'b1, alu_ref(req1_opcode, req1_func3, req1_func7, req1_op1, req1_op2)});
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        collect();
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
